// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// shift_sequencer_if : command/result/rotator bundle for shift_sequencer
// Revision 1.0
// ============================================================================
interface shift_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
);
   logic              start;
   logic [DATA_W-1:0] din;
   logic [CNT_W-1:0]  total_amt;
   logic              dir;
   logic [DATA_W-1:0] sh_in;
   logic [2:0]        sh_amt;
   logic              sh_lr;
   logic [DATA_W-1:0] sh_out;
   logic              ready;
   logic              busy;
   logic              done_tick;
   logic [DATA_W-1:0] dout;

   modport master (
      output start, din, total_amt, dir, sh_out,
      input  sh_in, sh_amt, sh_lr, ready, busy, done_tick, dout
   );

   modport slave (
      input  start, din, total_amt, dir, sh_out,
      output sh_in, sh_amt, sh_lr, ready, busy, done_tick, dout
   );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// shift_sequencer : multi-pass controller driving an external 8-bit rotator
// Revision 1.0
// ============================================================================
module shift_sequencer #(
   parameter int DATA_W   = 8,
   parameter int CNT_W    = 8,
   parameter int STEP_MAX = 7
) (
   input  wire logic        clk,
   input  wire logic        reset_n,
   shift_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_STEP_MAX = CNT_W'(STEP_MAX);

   state_t            r_state;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_dout;
   logic [CNT_W-1:0]  r_rem;
   logic              r_dir;
   logic              r_ready;
   logic              r_busy;
   logic              r_done_tick;

   logic [2:0]        w_step;
   logic              w_last;

   // step never exceeds rem, so rem cannot underflow
   assign w_step = (r_rem > C_STEP_MAX) ? 3'(STEP_MAX) : r_rem[2:0];
   assign w_last = (r_rem <= C_STEP_MAX);

   assign bus.sh_in     = r_acc;
   assign bus.sh_amt    = (r_state == S_RUN) ? w_step : 3'd0;
   assign bus.sh_lr     = r_dir;
   assign bus.ready     = r_ready;
   assign bus.busy      = r_busy;
   assign bus.done_tick = r_done_tick;
   assign bus.dout      = r_dout;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_rem       <= '0;
         r_dir       <= 1'b0;
         r_dout      <= '0;
         r_ready     <= 1'b1;
         r_busy      <= 1'b0;
         r_done_tick <= 1'b0;
      end else begin
         case (r_state)
            // DONE accepts a new command exactly like IDLE (no idle gap)
            S_IDLE, S_DONE: begin
               r_done_tick <= 1'b0;
               r_ready     <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
               if (bus.start) begin
                  r_acc <= bus.din;
                  r_rem <= bus.total_amt;
                  r_dir <= bus.dir;
                  if (bus.total_amt != '0) begin
                     r_state <= S_RUN;
                     r_ready <= 1'b0;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state     <= S_DONE;
                     r_dout      <= bus.din;
                     r_done_tick <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               r_acc <= bus.sh_out;
               r_rem <= r_rem - {{(CNT_W-3){1'b0}}, w_step};
               if (w_last) begin
                  r_state     <= S_DONE;
                  r_dout      <= bus.sh_out;
                  r_done_tick <= 1'b1;
                  r_ready     <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_ready     <= 1'b1;
               r_busy      <= 1'b0;
               r_done_tick <= 1'b0;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// tb_shift_sequencer : randomized + directed self-checking bench
// Revision 1.0
// ============================================================================
module tb_shift_sequencer;
   logic clk;
   logic reset_n;
   int   errors;
   int   checks;
   logic [7:0] exp_dout;

   shift_sequencer_if #(.DATA_W(8), .CNT_W(8)) bus ();

   shift_sequencer #(.DATA_W(8), .CNT_W(8), .STEP_MAX(7)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rot(input logic [7:0] x, input int a, input logic l);
      logic [15:0] t;
      t = {x, x};
      if (l) begin
         t = t << a;
         return t[15:8];
      end
      t = t >> a;
      return t[7:0];
   endfunction

   // combinational rotator the sequencer drives
   assign bus.sh_out = rot(bus.sh_in, int'(bus.sh_amt), bus.sh_lr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // now=1: drive start in the current (DONE) cycle, otherwise in the next cycle
   task automatic issue(input logic [7:0] d, input logic [7:0] a, input logic l, input bit now);
      if (!now) begin
         @(negedge clk);
         check("idle_done_low", 32'(bus.done_tick), 32'd0);
         check("idle_ready", 32'(bus.ready), 32'd1);
         check("idle_dout_hold", 32'(bus.dout), 32'(exp_dout));
      end
      bus.start     = 1'b1;
      bus.din       = d;
      bus.total_amt = a;
      bus.dir       = l;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.din       = 8'($urandom);
      bus.total_amt = 8'($urandom);
      bus.dir       = 1'($urandom);
   endtask

   // follows the command cycle by cycle until its done_tick cycle
   task automatic follow(input logic [7:0] d, input logic [7:0] a, input logic l, input bit poke);
      int passes;
      int remaining;
      passes = (int'(a) + 6) / 7;
      for (int n = 1; n <= passes + 1; n++) begin
         @(negedge clk);
         if (n == 2) bus.start = 1'b0;
         remaining = int'(a) - 7 * (n - 1);
         if (n <= passes) begin
            check("run_busy", 32'(bus.busy), 32'd1);
            check("run_ready", 32'(bus.ready), 32'd0);
            check("run_sh_amt", 32'(bus.sh_amt), 32'((remaining > 7) ? 7 : remaining));
            check("run_done_low", 32'(bus.done_tick), 32'd0);
            check("run_dout_hold", 32'(bus.dout), 32'(exp_dout));
         end else begin
            exp_dout = rot(d, int'(a) % 8, l);
            check("done_tick", 32'(bus.done_tick), 32'd1);
            check("done_ready", 32'(bus.ready), 32'd1);
            check("done_busy", 32'(bus.busy), 32'd0);
            check("done_sh_amt", 32'(bus.sh_amt), 32'd0);
            check("done_dout", 32'(bus.dout), 32'(exp_dout));
         end
         if (poke && n == 1 && passes >= 2) begin
            bus.start     = 1'b1;
            bus.din       = 8'($urandom);
            bus.total_amt = 8'($urandom);
            bus.dir       = 1'($urandom);
         end
      end
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      exp_dout      = 8'h00;
      reset_n       = 1'b0;
      bus.start     = 1'b0;
      bus.din       = 8'h00;
      bus.total_amt = 8'h00;
      bus.dir       = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done_tick), 32'd0);
      check("rst_dout", 32'(bus.dout), 32'd0);
      check("rst_sh_in", 32'(bus.sh_in), 32'd0);
      reset_n = 1'b1;

      // directed cases with hand-computed results
      issue(8'h81, 8'd1, 1'b1, 1'b0);   follow(8'h81, 8'd1, 1'b1, 1'b0);
      check("t1_dout", 32'(bus.dout), 32'h03);
      issue(8'h01, 8'd10, 1'b1, 1'b0);  follow(8'h01, 8'd10, 1'b1, 1'b0);
      check("t2_dout", 32'(bus.dout), 32'h04);
      issue(8'hA5, 8'd255, 1'b0, 1'b0); follow(8'hA5, 8'd255, 1'b0, 1'b0);
      check("t3_dout", 32'(bus.dout), 32'h4B);
      issue(8'h5A, 8'd0, 1'b1, 1'b0);   follow(8'h5A, 8'd0, 1'b1, 1'b0);
      check("t4_dout", 32'(bus.dout), 32'h5A);

      // start during RUN ignored, then start in DONE accepted back-to-back
      issue(8'h3C, 8'd30, 1'b1, 1'b0);  follow(8'h3C, 8'd30, 1'b1, 1'b1);
      issue(8'hC3, 8'd9, 1'b0, 1'b1);   follow(8'hC3, 8'd9, 1'b0, 1'b0);
      issue(8'h77, 8'd0, 1'b0, 1'b1);   follow(8'h77, 8'd0, 1'b0, 1'b0);

      // asynchronous reset in the second RUN cycle
      issue(8'h96, 8'd20, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("arst_ready", 32'(bus.ready), 32'd1);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done_tick), 32'd0);
      check("arst_dout", 32'(bus.dout), 32'd0);
      check("arst_sh_amt", 32'(bus.sh_amt), 32'd0);
      check("arst_sh_in", 32'(bus.sh_in), 32'd0);
      exp_dout = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("arst_no_done", 32'(bus.done_tick), 32'd0);
      end
      reset_n = 1'b1;
      issue(8'h12, 8'd20, 1'b0, 1'b0);  follow(8'h12, 8'd20, 1'b0, 1'b0);

      // randomized commands against the arithmetic reference
      for (int k = 0; k < 16; k++) begin
         logic [7:0] d;
         logic [7:0] a;
         logic       l;
         d = 8'($urandom);
         a = (k % 4 == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255));
         l = 1'($urandom);
         issue(d, a, l, (k % 3 == 1));
         follow(d, a, l, (k % 2 == 0));
      end

      @(negedge clk);
      check("final_done_low", 32'(bus.done_tick), 32'd0);
      check("final_dout_hold", 32'(bus.dout), 32'(exp_dout));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
